// File: rtl/msrr8_pkg.sv
// Shared encodings for the msrr8 serial feeder: downstream sel modes,
// feeder FSM states and the default byte width.
package msrr8_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b11;
    localparam logic [1:0] SEL_SHL  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/msrr8_serial_feeder_byte_hold_buf.sv
// Single-entry holding register in front of the feeder's shifter.
module byte_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             pop,
    input  logic             bypass,
    output logic             din_ready,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    logic push;

    // A pop on this edge frees the slot, so a new byte may land in it on the same edge.
    assign din_ready = !hold_full || pop;
    assign push      = din_valid && din_ready && !bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (push) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/msrr8_serial_feeder.sv
// Serializes parallel bytes into the msrr8latch Sin/sel inputs; optional MSB_FIRST_EN
// sends MSB first using the shift-left mode instead of LSB first with shift-right.
//
// state | meaning
// IDLE  | no byte shifting; sel=HOLD, sin=0
// SHIFT | one bit per clock; cnt counts bits already presented
module msrr8_serial_feeder
    import msrr8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sin,
    output logic [1:0]       sel,
    output logic             po_valid,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sh, sh_nxt, sh_adv, hold, load_byte;
    logic [1:0]       sel_nxt;
    logic             hold_full, hold_full_nxt;
    logic             term, pop, bypass, accept;
    logic             po_valid_nxt, busy_nxt;

`ifdef MSB_FIRST_EN
    localparam logic [1:0] SEL_RUN = SEL_SHL;
    localparam int         FIRST   = WIDTH - 1;
    assign sh_adv = {sh[WIDTH-2:0], 1'b0};
`else
    localparam logic [1:0] SEL_RUN = SEL_SHR;
    localparam int         FIRST   = 0;
    assign sh_adv = {1'b0, sh[WIDTH-1:1]};
`endif

    // The bit on the wire is the flop at the head of the shifter.
    assign sin = sh[FIRST];

    byte_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .pop       (pop),
        .bypass    (bypass),
        .din_ready (din_ready),
        .hold      (hold),
        .hold_full (hold_full)
    );

    always_comb begin
        term      = (state == SHIFT) && (cnt == LAST);
        pop       = hold_full && ((state == IDLE) || term);
        accept    = din_valid && din_ready;
        // An empty buffer on the last shift edge: feed the new byte straight to the shifter.
        bypass    = term && !hold_full && accept;
        load_byte = pop ? hold : din;

        state_nxt    = state;
        cnt_nxt      = cnt;
        sh_nxt       = sh;
        sel_nxt      = sel;
        po_valid_nxt = term;

        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    sh_nxt    = load_byte;
                    sel_nxt   = SEL_RUN;
                end
            end
            SHIFT: begin
                if (term && (pop || bypass)) begin
                    cnt_nxt = '0;
                    sh_nxt  = load_byte;
                    sel_nxt = SEL_RUN;
                end else if (term) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sh_nxt    = '0;
                    sel_nxt   = SEL_HOLD;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    sh_nxt  = sh_adv;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        hold_full_nxt = (accept && !bypass) || (hold_full && !pop);
        busy_nxt      = (state_nxt == SHIFT) || hold_full_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            sel      <= SEL_HOLD;
            po_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sh       <= sh_nxt;
            sel      <= sel_nxt;
            po_valid <= po_valid_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_msrr8_serial_feeder.sv
// Directed bench for msrr8_serial_feeder with a behavioural model of the downstream register.
module tb_msrr8_serial_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, sin, po_valid, busy;
    logic [1:0] sel;
    logic [7:0] po_model = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

`ifdef MSB_FIRST_EN
    localparam logic [1:0] SEL_RUN_EXP = 2'b10;
    localparam bit         MSB         = 1'b1;
`else
    localparam logic [1:0] SEL_RUN_EXP = 2'b11;
    localparam bit         MSB         = 1'b0;
`endif

    msrr8_serial_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sin       (sin),
        .sel       (sel),
        .po_valid  (po_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Downstream msrr8latch: 11 shifts right (Sin at MSB), 10 shifts left (Sin at LSB).
    always @(posedge clk) begin
        cyc++;
        case (sel)
            2'b11:   po_model <= {sin, po_model[7:1]};
            2'b10:   po_model <= {po_model[6:0], sin};
            default: po_model <= po_model;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic bit_at(input logic [7:0] b, input int k);
        return MSB ? b[7-k] : b[k];
    endfunction

    task automatic send_one(input logic [7:0] b, input string tg);
        din       = b;
        din_valid = 1'b1;
        check({tg, "_rdy"}, din_ready, 1);
        tick();
        din_valid = 1'b0;
        din       = 8'h00;
        check({tg, "_busy_e0"}, busy, 1);
        check({tg, "_sel_e0"}, sel, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("%s_sel_b%0d", tg, k), sel, SEL_RUN_EXP);
            check($sformatf("%s_sin_b%0d", tg, k), sin, bit_at(b, k));
            check($sformatf("%s_pv_b%0d", tg, k), po_valid, 0);
        end
        tick();
        check({tg, "_pv"}, po_valid, 1);
        check({tg, "_po"}, po_model, b);
        check({tg, "_sel_end"}, sel, 0);
        check({tg, "_sin_end"}, sin, 0);
        tick();
        check({tg, "_pv_off"}, po_valid, 0);
        check({tg, "_busy_end"}, busy, 0);
    endtask

    task automatic run_stream(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input string tg);
        logic [7:0] q[3];
        logic [7:0] pp[3];
        int         acc[3];
        int         pc[3];
        int         idx, np, gaps;
        bit         started, acc_now;
        logic       rdy2;
        q       = '{b0, b1, b2};
        pp      = '{8'h00, 8'h00, 8'h00};
        acc     = '{0, 0, 0};
        pc      = '{0, 0, 0};
        idx     = 0;
        np      = 0;
        gaps    = 0;
        started = 1'b0;
        rdy2    = 1'b1;
        din       = q[0];
        din_valid = 1'b1;
        for (int c = 0; c < 60 && np < 3; c++) begin
            acc_now = din_valid && din_ready;
            tick();
            if (acc_now && idx < 3) begin
                acc[idx] = cyc;
                idx++;
                if (idx < 3) din = q[idx];
                else begin
                    din_valid = 1'b0;
                    din       = 8'h00;
                end
                if (idx == 2) rdy2 = din_ready;
            end
            if (po_valid && np < 3) begin
                pp[np] = po_model;
                pc[np] = cyc;
                np++;
            end
            if (sel != 2'b00) started = 1'b1;
            else if (started && np < 3) gaps++;
        end
        din_valid = 1'b0;
        check({tg, "_pulses"}, np, 3);
        check({tg, "_accepts"}, idx, 3);
        check({tg, "_rdy_after2"}, rdy2, 0);
        check({tg, "_acc2_gap"}, acc[1] - acc[0], 1);
        check({tg, "_acc3_gap"}, acc[2] - acc[0], 9);
        check({tg, "_lat"}, pc[0] - acc[0], 9);
        check({tg, "_pv_gap1"}, pc[1] - pc[0], 8);
        check({tg, "_pv_gap2"}, pc[2] - pc[1], 8);
        check({tg, "_po0"}, pp[0], b0);
        check({tg, "_po1"}, pp[1], b1);
        check({tg, "_po2"}, pp[2], b2);
        check({tg, "_sel_gaps"}, gaps, 0);
        tick();
        check({tg, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int pv_seen, sel_nz;
        repeat (5) @(negedge clk);
        check("rst_sin", sin, 0);
        check("rst_sel", sel, 0);
        check("rst_pv", po_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", din_ready, 1);
        rst = 1'b1;

        for (int i = 0; i < 50; i++) begin
            tick();
            check($sformatf("idle_%0d", i), {sel, sin, po_valid, busy}, 0);
        end

        send_one(8'hA5, "a5");
        run_stream(8'h3C, 8'hFF, 8'h00, "b2b");
        run_stream(8'h11, 8'h22, 8'h33, "bp");

        // Reset mid-byte with a second byte waiting in the holding buffer.
        din       = 8'h81;
        din_valid = 1'b1;
        tick();
        din = 8'hEE;
        tick();
        din_valid = 1'b0;
        din       = 8'h00;
        repeat (3) tick();
        check("mid_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_sel", sel, 0);
        check("mid_sin", sin, 0);
        check("mid_rdy", din_ready, 1);
        check("mid_busy_rst", busy, 0);
        check("mid_pv", po_valid, 0);
        pv_seen = 0;
        sel_nz  = 0;
        repeat (2) begin
            tick();
            if (po_valid) pv_seen++;
            if (sel != 2'b00) sel_nz++;
        end
        rst = 1'b1;
        repeat (15) begin
            tick();
            if (po_valid) pv_seen++;
            if (sel != 2'b00) sel_nz++;
        end
        check("mid_no_pv", pv_seen, 0);
        check("mid_no_shift", sel_nz, 0);
        check("mid_rdy_after", din_ready, 1);
        send_one(8'h5A, "5a");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish before time limit");
        $fatal(1);
    end

endmodule
